// File: rtl/adain_seq_ctrl.sv
// adain_seq_ctrl
// Control sequencer for one AdaIN channel job. A job walks an N x N plane
// twice: first to accumulate the statistics, then to normalize every
// pixel. Between the two passes the sequencer steps the shift-amount
// generator through three statistics cycles and waits on an external
// inverse square-root unit. The datapath itself lives elsewhere; this
// block only produces handshakes, strobes and the sequencing code.
module adain_seq_ctrl #(
    parameter int N_MAX = 128,
    parameter int LW    = $clog2($clog2(N_MAX + 1)),
    parameter int CW    = 2 * $clog2(N_MAX) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] n_log2,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          invsqrt_start,
    input  logic          invsqrt_done,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          norm_en,
    output logic [2:0]    state,
    output logic [1:0]    l_count,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // State encoding is visible on the state port and decoded by the
    // shift-amount generator, so the codes are fixed.
    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_ACC  = 3'b001;
    localparam logic [2:0] S_STAT = 3'b010;
    localparam logic [2:0] S_ISQ  = 3'b011;
    localparam logic [2:0] S_NORM = 3'b100;
    localparam logic [2:0] S_FIN  = 3'b101;

    // Largest legal n_log2 for this build.
    localparam logic [LW-1:0] MAX_LOG2 = LW'($clog2(N_MAX));

    // Counter constants sized to the pixel counter.
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // Last statistics step index.
    localparam logic [1:0] L_LAST = 2'd2;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [2:0]    state_r;
    logic [1:0]    l_count_r;
    logic [CW-1:0] pix_cnt_r;
    logic [LW-1:0] n_log2_r;
    logic          first_isq_r;
    logic          err_r;

    // Next-state values
    logic [2:0]    state_nxt_s;
    logic [1:0]    l_count_nxt_s;
    logic [CW-1:0] pix_cnt_nxt_s;
    logic [LW-1:0] n_log2_nxt_s;
    logic          first_isq_nxt_s;
    logic          err_nxt_s;

    // Derived combinational terms
    logic          range_ok_s;
    logic [CW-1:0] total_s;
    logic [CW-1:0] last_cnt_s;
    logic          last_pix_s;
    logic          in_ready_s;
    logic          out_valid_s;
    logic          acc_en_s;
    logic          norm_en_s;
    logic          acc_clr_s;

    // A requested edge length is only legal up to N_MAX.
    assign range_ok_s = (n_log2 <= MAX_LOG2);

    // Pixels per pass is N*N = 2^(2*n_log2). The counter is one bit wider
    // than the largest index so N_MAX*N_MAX itself is representable and
    // nothing wraps at the top size.
    assign total_s    = CNT_ONE << {n_log2_r, 1'b0};
    assign last_cnt_s = total_s - CNT_ONE;
    assign last_pix_s = (pix_cnt_r == last_cnt_s);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Sequencing decisions: job launch, pass counting, statistics steps
    // and the inverse-sqrt wait.
    always_comb begin
        state_nxt_s     = state_r;
        l_count_nxt_s   = l_count_r;
        pix_cnt_nxt_s   = pix_cnt_r;
        n_log2_nxt_s    = n_log2_r;
        first_isq_nxt_s = 1'b0;
        err_nxt_s       = 1'b0;

        case (state_r)
            S_IDLE: begin
                l_count_nxt_s = 2'd0;
                if (start) begin
                    if (range_ok_s) begin
                        // Accept the job; the size is frozen for its
                        // whole duration.
                        state_nxt_s   = S_ACC;
                        n_log2_nxt_s  = n_log2;
                        pix_cnt_nxt_s = CNT_ZERO;
                    end else begin
                        // Reject an oversize request and stay put.
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end

            S_ACC: begin
                // in_ready is high for the whole pass, so every valid
                // beat is a transfer; idle beats simply hold the count.
                if (in_valid) begin
                    if (last_pix_s) begin
                        state_nxt_s   = S_STAT;
                        pix_cnt_nxt_s = CNT_ZERO;
                    end else begin
                        pix_cnt_nxt_s = pix_cnt_r + CNT_ONE;
                    end
                end else begin
                    pix_cnt_nxt_s = pix_cnt_r;
                end
            end

            S_STAT: begin
                // Three back-to-back statistics steps, 0 then 1 then 2.
                if (l_count_r == L_LAST) begin
                    state_nxt_s     = S_ISQ;
                    l_count_nxt_s   = 2'd0;
                    first_isq_nxt_s = 1'b1;
                end else begin
                    l_count_nxt_s = l_count_r + 2'd1;
                end
            end

            S_ISQ: begin
                // A done seen on the launch cycle belongs to an earlier
                // request (or is a glitch) and must not end the wait.
                if (!first_isq_r && invsqrt_done) begin
                    state_nxt_s = S_NORM;
                end else begin
                    state_nxt_s = S_ISQ;
                end
            end

            S_NORM: begin
                // A transfer needs both sides; a stalled sink holds the
                // counter so no pixel is dropped.
                if (in_valid && out_ready) begin
                    if (last_pix_s) begin
                        state_nxt_s   = S_FIN;
                        pix_cnt_nxt_s = CNT_ZERO;
                    end else begin
                        pix_cnt_nxt_s = pix_cnt_r + CNT_ONE;
                    end
                end else begin
                    pix_cnt_nxt_s = pix_cnt_r;
                end
            end

            S_FIN: begin
                state_nxt_s = S_IDLE;
            end

            default: begin
                // Unreachable codes recover to a clean idle.
                state_nxt_s   = S_IDLE;
                l_count_nxt_s = 2'd0;
                pix_cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------

    // Sequencer registers with synchronous reset taking priority over
    // every request and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            l_count_r   <= 2'd0;
            pix_cnt_r   <= CNT_ZERO;
            n_log2_r    <= {LW{1'b0}};
            first_isq_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            l_count_r   <= l_count_nxt_s;
            pix_cnt_r   <= pix_cnt_nxt_s;
            n_log2_r    <= n_log2_nxt_s;
            first_isq_r <= first_isq_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------

    // Pixel handshakes and datapath enables, decoded from registered
    // state so they are quiet outside their own pass.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        acc_en_s    = 1'b0;
        norm_en_s   = 1'b0;
        case (state_r)
            S_ACC: begin
                in_ready_s = 1'b1;
                acc_en_s   = in_valid;
            end
            S_NORM: begin
                in_ready_s  = out_ready;
                out_valid_s = in_valid;
                norm_en_s   = in_valid & out_ready;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
                acc_en_s    = 1'b0;
                norm_en_s   = 1'b0;
            end
        endcase
    end

    // Accumulator clear coincides with the accepting cycle so the first
    // pixel of the pass lands in a clean accumulator; reset suppresses it.
    always_comb begin
        if (!rst && (state_r == S_IDLE) && start && range_ok_s) begin
            acc_clr_s = 1'b1;
        end else begin
            acc_clr_s = 1'b0;
        end
    end

    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_s;
    assign acc_en        = acc_en_s;
    assign norm_en       = norm_en_s;
    assign acc_clr       = acc_clr_s;
    assign invsqrt_start = first_isq_r;
    assign state         = state_r;
    assign l_count       = l_count_r;
    assign busy          = (state_r != S_IDLE);
    assign done          = (state_r == S_FIN);
    assign err           = err_r;

endmodule

// File: tb/tb_adain_seq_ctrl.sv
// tb_adain_seq_ctrl
// Randomized bench for the AdaIN sequencer. The reference model tracks a
// job only by its progress counters (pixels accumulated, statistics steps
// done, inverse-sqrt answered, pixels normalized, finish seen) and derives
// the expected outputs of each cycle from those.
module tb_adain_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] n_log2 = 3'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       invsqrt_done = 1'b0;
    logic       in_ready, out_valid, invsqrt_start, acc_clr, acc_en, norm_en;
    logic [2:0] state;
    logic [1:0] l_count;
    logic       busy, done, err;

    // Second build with a smaller maximum, used for range rejection.
    logic       start64 = 1'b0;
    logic [2:0] n64 = 3'd0;
    logic       in_ready64, out_valid64, invsqrt_start64, acc_clr64, acc_en64, norm_en64;
    logic [2:0] state64;
    logic [1:0] l_count64;
    logic       busy64, done64, err64;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    adain_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .n_log2(n_log2),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .invsqrt_start(invsqrt_start), .invsqrt_done(invsqrt_done),
        .acc_clr(acc_clr), .acc_en(acc_en), .norm_en(norm_en),
        .state(state), .l_count(l_count),
        .busy(busy), .done(done), .err(err)
    );

    adain_seq_ctrl #(.N_MAX(64)) dut64 (
        .clk(clk), .rst(rst), .start(start64), .n_log2(n64),
        .in_valid(in_valid), .in_ready(in_ready64),
        .out_valid(out_valid64), .out_ready(out_ready),
        .invsqrt_start(invsqrt_start64), .invsqrt_done(invsqrt_done),
        .acc_clr(acc_clr64), .acc_en(acc_en64), .norm_en(norm_en64),
        .state(state64), .l_count(l_count64),
        .busy(busy64), .done(done64), .err(err64)
    );

    // One job from launch to the idle cycle after FIN (or after an abort).
    // Phase codes are the externally visible state codes.
    task automatic run_job(input int n, input int vmode, input int vpct, input int rpct,
                           input int isq_dly, input bit spur, input bit hold_start,
                           input int abort_at, input int stall_at,
                           output int acc_cnt, output int acc_cyc, output int norm_cnt,
                           output int done_cnt, output int isq_cnt);
        int total, m_acc, m_norm, m_stat, m_isq, ph, cyc, stall_left;
        bit isq_ok, fin_seen, go_idle, stalled, iv, orr, dn, rs, finished, tog;
        logic [13:0] exp_v, obs_v;
        total = 1 << (2 * n);
        m_acc = 0; m_norm = 0; m_stat = 0; m_isq = 0; cyc = 0; stall_left = 0;
        isq_ok = 1'b0; fin_seen = 1'b0; go_idle = 1'b0; stalled = 1'b0;
        finished = 1'b0; tog = 1'b0;
        acc_cnt = 0; acc_cyc = 0; norm_cnt = 0; done_cnt = 0; isq_cnt = 0;

        // Launch cycle: idle, request accepted, accumulator clear.
        @(negedge clk);
        rst = 1'b0; start = 1'b1; n_log2 = 3'(n);
        in_valid = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        invsqrt_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        exp_v = 14'b000_00_000000001;
        obs_v = {state, l_count, in_ready, out_valid, acc_en, norm_en,
                 invsqrt_start, done, busy, err, acc_clr};
        checks++;
        if (obs_v !== exp_v) begin
            fails++;
            $display("FAIL launch n=%0d: observed %b expected %b", n, obs_v, exp_v);
        end

        while (!finished) begin
            @(negedge clk);
            cyc++;
            if (go_idle)               ph = 0;
            else if (m_acc < total)    ph = 1;
            else if (m_stat < 3)       ph = 2;
            else if (!isq_ok)          ph = 3;
            else if (m_norm < total)   ph = 4;
            else if (!fin_seen)        ph = 5;
            else                       ph = 0;

            tog = ~tog;
            if (vmode == 1 && ph == 1) iv = ~tog;
            else                       iv = ($urandom_range(0, 99) < vpct);
            if (ph == 4 && !stalled && m_norm == stall_at) begin
                stalled = 1'b1;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                orr = 1'b0;
                stall_left--;
            end else begin
                orr = ($urandom_range(0, 99) < rpct);
            end
            if (ph == 3) dn = (m_isq == 0) ? spur : (m_isq == isq_dly);
            else         dn = spur ? ($urandom_range(0, 3) == 0) : 1'b0;
            rs = (abort_at == 1 && ph == 1 && m_acc == 5) ||
                 (abort_at == 2 && ph == 3 && m_isq == 1);

            rst = rs;
            start = (ph != 0) ? (hold_start | rs) : 1'b0;
            n_log2 = hold_start ? 3'd7 : 3'($urandom_range(0, 7));
            in_valid = iv; out_ready = orr; invsqrt_done = dn;
            #1;
            exp_v = {3'(ph), (ph == 2) ? 2'(m_stat) : 2'd0,
                     (ph == 1) || (ph == 4 && orr), (ph == 4 && iv),
                     (ph == 1 && iv), (ph == 4 && iv && orr),
                     (ph == 3 && m_isq == 0), (ph == 5), (ph != 0), 1'b0, 1'b0};
            obs_v = {state, l_count, in_ready, out_valid, acc_en, norm_en,
                     invsqrt_start, done, busy, err, acc_clr};
            checks++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("FAIL cycle n=%0d cyc=%0d phase=%0d: observed %b expected %b",
                         n, cyc, ph, obs_v, exp_v);
            end
            if (acc_en === 1'b1)        acc_cnt++;
            if (state === 3'b001)       acc_cyc++;
            if (norm_en === 1'b1)       norm_cnt++;
            if (done === 1'b1)          done_cnt++;
            if (invsqrt_start === 1'b1) isq_cnt++;

            if (rs) begin
                go_idle = 1'b1;
            end else begin
                case (ph)
                    0: finished = 1'b1;
                    1: if (iv) m_acc++;
                    2: m_stat++;
                    3: begin
                        if (m_isq > 0 && dn) isq_ok = 1'b1;
                        m_isq++;
                    end
                    4: if (iv && orr) m_norm++;
                    5: fin_seen = 1'b1;
                    default: ;
                endcase
            end
            if (!finished && cyc > 70000) begin
                checks++;
                fails++;
                $display("FAIL timeout n=%0d: still running after %0d cycles, required to finish", n, cyc);
                finished = 1'b1;
            end
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; invsqrt_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; n_log2 = 3'd2; in_valid = 1'b1;
        out_ready = 1'b1; invsqrt_done = 1'b1; start64 = 1'b1; n64 = 3'd7;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({state, l_count, busy, done, err, in_ready, acc_clr, invsqrt_start,
             acc_en, norm_en, out_valid} !== 14'b0) begin
            fails++;
            $display("FAIL reset_state: observed %b required all zero",
                     {state, l_count, busy, done, err, in_ready, acc_clr, invsqrt_start,
                      acc_en, norm_en, out_valid});
        end
        checks++;
        if ({state64, l_count64, busy64, done64, err64, acc_clr64, in_ready64,
             out_valid64, acc_en64, norm_en64, invsqrt_start64} !== 14'b0) begin
            fails++;
            $display("FAIL reset_state64: observed state %b busy %b err %b, required zero",
                     state64, busy64, err64);
        end
        rst = 1'b0; start = 1'b0; start64 = 1'b0; in_valid = 1'b0; invsqrt_done = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (state !== 3'b000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: observed state %b busy %b required 000 0", state, busy);
        end
    endtask

    task automatic test_basic();
        int a, ac, nm, dn, is;
        run_job(2, 0, 100, 100, 5, 1'b0, 1'b0, 0, -1, a, ac, nm, dn, is);
        checks++;
        if ({a, nm, dn, is} !== {32'd16, 32'd16, 32'd1, 32'd1}) begin
            fails++;
            $display("FAIL basic_counts: observed acc %0d norm %0d done %0d isq %0d required 16 16 1 1",
                     a, nm, dn, is);
        end
    endtask

    task automatic test_n0();
        int a, ac, nm, dn, is;
        run_job(0, 0, 100, 100, 2, 1'b0, 1'b0, 0, -1, a, ac, nm, dn, is);
        checks++;
        if ({a, nm, dn} !== {32'd1, 32'd1, 32'd1}) begin
            fails++;
            $display("FAIL n0_counts: observed acc %0d norm %0d done %0d required 1 1 1", a, nm, dn);
        end
    endtask

    task automatic test_spurious_done();
        int a, ac, nm, dn, is;
        run_job(1, 0, 70, 70, 3, 1'b1, 1'b0, 0, -1, a, ac, nm, dn, is);
        checks++;
        if ({a, nm, dn, is} !== {32'd4, 32'd4, 32'd1, 32'd1}) begin
            fails++;
            $display("FAIL spurious_counts: observed acc %0d norm %0d done %0d isq %0d required 4 4 1 1",
                     a, nm, dn, is);
        end
    endtask

    task automatic test_reset_mid();
        int a, ac, nm, dn, is;
        run_job(2, 0, 100, 100, 4, 1'b0, 1'b0, 1, -1, a, ac, nm, dn, is);
        checks++;
        if (dn !== 0) begin
            fails++;
            $display("FAIL abort_acc_done: observed %0d done pulses required 0", dn);
        end
        run_job(2, 0, 80, 100, 4, 1'b0, 1'b0, 2, -1, a, ac, nm, dn, is);
        checks++;
        if ({nm, dn} !== {32'd0, 32'd0}) begin
            fails++;
            $display("FAIL abort_isq: observed norm %0d done %0d required 0 0", nm, dn);
        end
        run_job(3, 0, 75, 75, 3, 1'b0, 1'b0, 0, 7, a, ac, nm, dn, is);
        checks++;
        if ({a, nm, dn} !== {32'd64, 32'd64, 32'd1}) begin
            fails++;
            $display("FAIL after_abort_job: observed acc %0d norm %0d done %0d required 64 64 1",
                     a, nm, dn);
        end
    endtask

    task automatic test_err();
        @(negedge clk);
        start64 = 1'b1; n64 = 3'd6;
        #1;
        checks++;
        if (acc_clr64 !== 1'b1) begin
            fails++;
            $display("FAIL range_legal_clr: observed %b required 1", acc_clr64);
        end
        n64 = 3'd7;
        #1;
        checks++;
        if (acc_clr64 !== 1'b0) begin
            fails++;
            $display("FAIL range_illegal_clr: observed %b required 0", acc_clr64);
        end
        @(negedge clk);
        start64 = 1'b0;
        #1;
        checks++;
        if ({err64, state64, busy64} !== 5'b1_000_0) begin
            fails++;
            $display("FAIL err_pulse: observed err %b state %b busy %b required 1 000 0",
                     err64, state64, busy64);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({err64, state64, l_count64, done64, in_ready64, out_valid64,
             acc_en64, norm_en64, invsqrt_start64} !== 13'b0) begin
            fails++;
            $display("FAIL err_one_cycle: observed err %b state %b required 0 000", err64, state64);
        end
    endtask

    task automatic test_random();
        int a, ac, nm, dn, is, n;
        for (int j = 0; j < 6; j++) begin
            n = int'($urandom_range(0, 3));
            run_job(n, 0, int'($urandom_range(40, 100)), int'($urandom_range(40, 100)),
                    int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'b0, 0,
                    int'($urandom_range(0, 3)), a, ac, nm, dn, is);
            checks++;
            if ({a, nm, dn, is} !== {32'(1 << (2 * n)), 32'(1 << (2 * n)), 32'd1, 32'd1}) begin
                fails++;
                $display("FAIL random_job%0d n=%0d: observed acc %0d norm %0d done %0d isq %0d",
                         j, n, a, nm, dn, is);
            end
        end
    endtask

    task automatic test_big();
        int a, ac, nm, dn, is;
        run_job(7, 1, 100, 100, 2, 1'b0, 1'b1, 0, 100, a, ac, nm, dn, is);
        checks++;
        if ({a, ac} !== {32'd16384, 32'd32768}) begin
            fails++;
            $display("FAIL big_acc: observed %0d transfers in %0d cycles required 16384 in 32768", a, ac);
        end
        checks++;
        if ({nm, dn} !== {32'd16384, 32'd1}) begin
            fails++;
            $display("FAIL big_norm: observed norm %0d done %0d required 16384 1", nm, dn);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_n0();
        test_spurious_done();
        test_reset_mid();
        test_err();
        test_random();
        test_big();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adain_seq_ctrl.md
ADAIN_SEQ_CTRL -- requirements
Module: adain_seq_ctrl

Interface
REQ-001 SHALL have parameter N_MAX, default 128, meaning maximum spatial edge length N (power of two).
REQ-002 SHALL have parameter LW, default $clog2($clog2(N_MAX+1)) (=3), meaning width of n_log2.
REQ-003 SHALL have parameter CW, default 2*$clog2(N_MAX)+1 (=15), meaning width of the pixel counter.
REQ-004 SHALL have ports: clk  in  1  clock.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begin one AdaIN channel job; n_log2  in  LW  log2(N), sampled with start.
REQ-007 in_valid  in  1 / in_ready  out  1  input pixel handshake.
REQ-008 out_valid  out  1 / out_ready  in  1  normalized pixel handshake.
REQ-009 invsqrt_start  out  1  one-cycle pulse; invsqrt_done  in  1  inverse-sqrt result ready.
REQ-010 acc_clr  out  1, acc_en  out  1, norm_en  out  1  datapath strobes.
REQ-011 state  out  3, l_count  out  2  sequencing code consumed by the shift-amount generator.
REQ-012 busy  out  1, done  out  1 (pulse), err  out  1 (pulse).

Function
REQ-013 SHALL implement FSM: IDLE=000, ACC=001, STAT=010, ISQ=011, NORM=100, FIN=101; state output equals the encoding, registered.
REQ-014 IDLE: start=1 and n_log2<=log2(N_MAX) -> ACC next cycle, latch n_log2, pix_cnt<=0, acc_clr=1 for exactly that transition cycle.
REQ-015 IDLE: start=1 and n_log2>log2(N_MAX) -> err=1 one cycle, stay IDLE.
REQ-016 start SHALL be ignored whenever state!=IDLE.
REQ-017 ACC: in_ready=1; acc_en=in_valid; each accepted pixel increments pix_cnt; on accepting pixel number 2^(2*n_log2) (pix_cnt==TOTAL-1 and in_valid) -> STAT, pix_cnt<=0.
REQ-018 STAT: l_count=0,1,2 on three consecutive cycles (0 on entry); after l_count==2 -> ISQ with l_count<=0.
REQ-019 l_count SHALL be 0 in every state other than STAT.
REQ-020 ISQ: invsqrt_start=1 on the first ISQ cycle only; wait for invsqrt_done (ignored on that first cycle) -> NORM.
REQ-021 NORM: in_ready=out_ready; out_valid=in_valid; norm_en=in_valid&out_ready; count transfers; on transfer number TOTAL -> FIN.
REQ-022 FIN: done=1 for one cycle -> IDLE; busy=1 in all states except IDLE.
REQ-023 in_ready, acc_en, norm_en, out_valid SHALL be 0 outside ACC/NORM respectively (combinational from registered state).
REQ-024 n_log2=0 (N=1): ACC and NORM each complete after exactly one transfer.
REQ-025 pix_cnt SHALL be CW bits; TOTAL = 1<<(2*n_log2), no wrap at N_MAX (TOTAL=16384 fits).
REQ-026 in_valid deasserted mid-pass SHALL stall the counter without state change; out_ready low in NORM SHALL stall without loss.
REQ-027 invsqrt_done asserted outside ISQ SHALL be ignored.

Reset
REQ-028 rst SHALL, at any cycle including mid-pass, force state=IDLE, l_count=0, pix_cnt=0, latched n_log2=0, and all strobes/pulses/busy to 0 on the next edge.
REQ-029 rst has priority over start and all handshakes in the same cycle.

Verification
REQ-030 n_log2=2, continuous in_valid -> 16 ACC transfers, STAT l_count 0,1,2, invsqrt_start 1 pulse, invsqrt_done after 5 cycles, 16 NORM transfers, done 1 pulse, back to IDLE.
REQ-031 n_log2=0 -> acc_en exactly 1 cycle, norm_en exactly 1 cycle, done asserted; n_log2=7 -> exactly 16384 ACC transfers.
REQ-032 n_log2=7 fed with in_valid toggling 1/0 -> ACC takes 32768 cycles, count exact; out_ready held 0 for 10 cycles in NORM -> no norm_en, no count change.
REQ-033 start with n_log2=7 held high while busy -> no restart, single done; start with out-of-range value (N_MAX=64, n_log2=7) -> err pulse, state stays 000.
REQ-034 rst asserted at ACC pixel 5 and at ISQ -> next cycle state=000, busy=0, in_ready=0; new start runs full job correctly.
REQ-035 invsqrt_done pulsed during ACC and on ISQ entry cycle -> ignored; only later done advances to NORM.
